// File: rtl/pipeline_handshake_replicator_pkg.sv
// pipeline_handshake_replicator_pkg: shared slot state encoding and width helper
package pipeline_handshake_replicator_pkg;

    typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/pipeline_handshake_replicator_slot.sv
// replicator_slot: one {data,count} holding register with a full flag
module replicator_slot
    import pipeline_handshake_replicator_pkg::*;
#(
    parameter int WORD_WIDTH  = 8,
    parameter int COUNT_WIDTH = 5
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   load,
    input  logic                   unload,
    input  logic [WORD_WIDTH-1:0]  load_data,
    input  logic [COUNT_WIDTH-1:0] load_count,
    output logic                   full,
    output logic [WORD_WIDTH-1:0]  data,
    output logic [COUNT_WIDTH-1:0] count
);

    slot_state_e            state_q, state_d;
    logic [WORD_WIDTH-1:0]  data_q, data_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    // load wins over unload so a retiring slot can be refilled in the same edge
    always_comb begin
        state_d = load ? SLOT_FULL : (unload ? SLOT_EMPTY : state_q);
        data_d  = load ? load_data : data_q;
        count_d = load ? load_count : count_q;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign full  = (state_q == SLOT_FULL);
    assign data  = data_q;
    assign count = count_q;

endmodule

// File: rtl/pipeline_handshake_replicator.sv
// pipeline_handshake_replicator: emits each accepted word as N ready/valid beats,
// with a one-item queue behind the head so consecutive items stream without bubbles.
module pipeline_handshake_replicator
    import pipeline_handshake_replicator_pkg::*;
#(
    parameter  int WORD_WIDTH         = 8,
    parameter  int MAX_REPEAT_COUNT   = 16,
    localparam int REPEAT_COUNT_WIDTH = clog2(MAX_REPEAT_COUNT) + 1
) (
    input  logic                          clock,
    input  logic                          clear,
    input  logic                          input_valid,
    output logic                          input_ready,
    input  logic [WORD_WIDTH-1:0]         input_data,
    input  logic [REPEAT_COUNT_WIDTH-1:0] input_repeat_count,
    output logic                          input_count_error,
    input  logic                          abort_current,
    output logic                          output_valid,
    input  logic                          output_ready,
    output logic [WORD_WIDTH-1:0]         output_data,
    output logic [REPEAT_COUNT_WIDTH-1:0] output_repeat_index,
    output logic                          output_last
);

    localparam logic [REPEAT_COUNT_WIDTH-1:0] REPEAT_ZERO = '0;
    localparam logic [REPEAT_COUNT_WIDTH-1:0] REPEAT_ONE  = REPEAT_COUNT_WIDTH'(1);
    localparam logic [REPEAT_COUNT_WIDTH-1:0] REPEAT_MAX  = REPEAT_COUNT_WIDTH'(MAX_REPEAT_COUNT);

    logic                          head_full, queue_full;
    logic [WORD_WIDTH-1:0]         head_data, queue_data;
    logic [REPEAT_COUNT_WIDTH-1:0] head_count, queue_count;
    logic                          out_hs, in_hs, head_is_last, head_retire, head_can_load;
    logic                          head_load, queue_load, queue_unload, direct_load, in_nonzero;
    logic [WORD_WIDTH-1:0]         head_load_data;
    logic [REPEAT_COUNT_WIDTH-1:0] in_count, head_load_count;
    logic                          enable_q, enable_d;
    logic                          count_error_q, count_error_d;
    logic [REPEAT_COUNT_WIDTH-1:0] index_q, index_d;

    always_comb begin
        out_hs          = head_full & output_ready;
        head_is_last    = (index_q == head_count - REPEAT_ONE);
        head_retire     = head_full & ((out_hs & head_is_last) | abort_current);
        head_can_load   = ~head_full | head_retire;
        queue_unload    = queue_full & head_can_load;
        input_ready     = enable_q & (~queue_full | queue_unload);
        in_hs           = input_valid & input_ready;
        in_count        = (input_repeat_count > REPEAT_MAX) ? REPEAT_MAX : input_repeat_count;
        in_nonzero      = (in_count != REPEAT_ZERO);
        // an empty queue lets the input go straight into a free head
        direct_load     = in_hs & in_nonzero & head_can_load & ~queue_full;
        queue_load      = in_hs & in_nonzero & ~direct_load;
        head_load       = queue_unload | direct_load;
        head_load_data  = queue_full ? queue_data : input_data;
        head_load_count = queue_full ? queue_count : in_count;
        index_d         = head_load ? REPEAT_ZERO : (out_hs ? index_q + REPEAT_ONE : index_q);
        count_error_d   = in_hs & (input_repeat_count > REPEAT_MAX);
        enable_d        = 1'b1;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            enable_q      <= 1'b0;
            count_error_q <= 1'b0;
            index_q       <= '0;
        end else begin
            enable_q      <= enable_d;
            count_error_q <= count_error_d;
            index_q       <= index_d;
        end
    end

    replicator_slot #(.WORD_WIDTH(WORD_WIDTH), .COUNT_WIDTH(REPEAT_COUNT_WIDTH)) u_head (
        .clock      (clock),
        .clear      (clear),
        .load       (head_load),
        .unload     (head_retire),
        .load_data  (head_load_data),
        .load_count (head_load_count),
        .full       (head_full),
        .data       (head_data),
        .count      (head_count)
    );

    replicator_slot #(.WORD_WIDTH(WORD_WIDTH), .COUNT_WIDTH(REPEAT_COUNT_WIDTH)) u_queue (
        .clock      (clock),
        .clear      (clear),
        .load       (queue_load),
        .unload     (queue_unload),
        .load_data  (input_data),
        .load_count (in_count),
        .full       (queue_full),
        .data       (queue_data),
        .count      (queue_count)
    );

    assign output_valid        = head_full;
    assign output_data         = head_data;
    assign output_repeat_index = index_q;
    assign output_last         = head_full & head_is_last;
    assign input_count_error   = count_error_q;

endmodule

// File: tb/tb_pipeline_handshake_replicator.sv
// tb_pipeline_handshake_replicator: directed vectors with hand-computed expected beats
module tb_pipeline_handshake_replicator;

    logic       clock, clear;
    logic       input_valid, input_ready, input_count_error, abort_current;
    logic [7:0] input_data, output_data;
    logic [4:0] input_repeat_count, output_repeat_index;
    logic       output_valid, output_ready, output_last;
    int         passed, total;

    pipeline_handshake_replicator #(.WORD_WIDTH(8), .MAX_REPEAT_COUNT(16)) dut (
        .clock               (clock),
        .clear               (clear),
        .input_valid         (input_valid),
        .input_ready         (input_ready),
        .input_data          (input_data),
        .input_repeat_count  (input_repeat_count),
        .input_count_error   (input_count_error),
        .abort_current       (abort_current),
        .output_valid        (output_valid),
        .output_ready        (output_ready),
        .output_data         (output_data),
        .output_repeat_index (output_repeat_index),
        .output_last         (output_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic [4:0] c,
                        input logic r, input logic a);
        @(posedge clock);
        #1;
        input_valid = v;
        input_data = d;
        input_repeat_count = c;
        output_ready = r;
        abort_current = a;
        @(negedge clock);
    endtask

    task automatic beat(input string tag, input logic v, input logic [7:0] d,
                        input logic [4:0] i, input logic l);
        check({tag, " valid"}, 32'(output_valid), 32'(v));
        if (v) begin
            check({tag, " data"}, 32'(output_data), 32'(d));
            check({tag, " index"}, 32'(output_repeat_index), 32'(i));
            check({tag, " last"}, 32'(output_last), 32'(l));
        end
    endtask

    initial begin
        passed = 0;
        total = 0;
        clear = 1'b1;
        input_valid = 1'b0;
        input_data = '0;
        input_repeat_count = '0;
        output_ready = 1'b0;
        abort_current = 1'b0;
        #3;
        check("reset input_ready", 32'(input_ready), 0);
        check("reset output_valid", 32'(output_valid), 0);
        check("reset output_data", 32'(output_data), 0);
        check("reset count_error", 32'(input_count_error), 0);
        @(negedge clock);
        clear = 1'b0;
        #1;
        check("ready before first edge", 32'(input_ready), 0);

        // single item, count 3
        step(1, 8'hA5, 3, 1, 0);
        check("a5 input_ready", 32'(input_ready), 1);
        beat("a5 pre", 0, 0, 0, 0);
        step(0, 0, 0, 1, 0); beat("a5 b0", 1, 8'hA5, 0, 0);
        step(0, 0, 0, 1, 0); beat("a5 b1", 1, 8'hA5, 1, 0);
        step(0, 0, 0, 1, 0); beat("a5 b2", 1, 8'hA5, 2, 1);
        step(0, 0, 0, 1, 0); beat("a5 done", 0, 0, 0, 0);

        // back-to-back items without bubble
        step(1, 8'h11, 2, 1, 0); beat("bb pre", 0, 0, 0, 0);
        step(1, 8'h22, 3, 1, 0); beat("bb 11a", 1, 8'h11, 0, 0);
        check("bb queue ready", 32'(input_ready), 1);
        step(0, 0, 0, 1, 0); beat("bb 11b", 1, 8'h11, 1, 1);
        step(0, 0, 0, 1, 0); beat("bb 22a", 1, 8'h22, 0, 0);
        step(0, 0, 0, 1, 0); beat("bb 22b", 1, 8'h22, 1, 0);
        step(0, 0, 0, 1, 0); beat("bb 22c", 1, 8'h22, 2, 1);
        step(0, 0, 0, 1, 0); beat("bb done", 0, 0, 0, 0);

        // zero-count item is swallowed
        step(1, 8'h44, 1, 1, 0); beat("z pre", 0, 0, 0, 0);
        step(1, 8'h33, 0, 1, 0); beat("z 44", 1, 8'h44, 0, 1);
        check("z ready with count 0", 32'(input_ready), 1);
        step(1, 8'h55, 1, 1, 0); beat("z gap", 0, 0, 0, 0);
        step(0, 0, 0, 1, 0); beat("z 55", 1, 8'h55, 0, 1);
        step(0, 0, 0, 1, 0); beat("z done", 0, 0, 0, 0);

        // over-range count clamps to 16 and flags an error
        step(1, 8'h99, 17, 1, 0);
        check("clamp err before", 32'(input_count_error), 0);
        step(0, 0, 0, 1, 0);
        check("clamp err pulse", 32'(input_count_error), 1);
        for (int i = 0; i < 16; i++) begin
            beat($sformatf("clamp b%0d", i), 1, 8'h99, 5'(i), i == 15);
            if (i == 1) check("clamp err drop", 32'(input_count_error), 0);
            step(0, 0, 0, 1, 0);
        end
        beat("clamp done", 0, 0, 0, 0);

        // abort concurrent with handshake on index 2; queued item follows
        step(1, 8'h66, 8, 1, 0); beat("ab pre", 0, 0, 0, 0);
        step(1, 8'h77, 2, 1, 0); beat("ab 66a", 1, 8'h66, 0, 0);
        step(0, 0, 0, 1, 0); beat("ab 66b", 1, 8'h66, 1, 0);
        step(0, 0, 0, 1, 1); beat("ab 66c", 1, 8'h66, 2, 0);
        step(0, 0, 0, 1, 0); beat("ab 77a", 1, 8'h77, 0, 0);
        step(0, 0, 0, 1, 0); beat("ab 77b", 1, 8'h77, 1, 1);
        step(0, 0, 0, 1, 0); beat("ab done", 0, 0, 0, 0);
        step(0, 0, 0, 1, 1); beat("ab empty", 0, 0, 0, 0);

        // stall stability, then asynchronous clear mid-item
        step(1, 8'hC3, 4, 0, 0); beat("st pre", 0, 0, 0, 0);
        step(0, 0, 0, 0, 0); beat("st c3 0", 1, 8'hC3, 0, 0);
        step(0, 0, 0, 0, 0); beat("st c3 0 hold", 1, 8'hC3, 0, 0);
        step(1, 8'hD4, 2, 1, 0); beat("st c3 0 go", 1, 8'hC3, 0, 0);
        step(0, 0, 0, 0, 0); beat("st c3 1", 1, 8'hC3, 1, 0);
        check("st queue full ready", 32'(input_ready), 0);
        step(0, 0, 0, 1, 0); beat("st c3 1 hold", 1, 8'hC3, 1, 0);
        #2;
        clear = 1'b1;
        #1;
        check("clr valid", 32'(output_valid), 0);
        check("clr data", 32'(output_data), 0);
        check("clr index", 32'(output_repeat_index), 0);
        check("clr last", 32'(output_last), 0);
        check("clr ready", 32'(input_ready), 0);
        @(posedge clock);
        #1;
        clear = 1'b0;
        @(negedge clock);
        check("clr ready after release", 32'(input_ready), 0);
        step(0, 0, 0, 1, 0); beat("clr no stale a", 0, 0, 0, 0);
        check("clr ready back", 32'(input_ready), 1);
        step(1, 8'hE7, 1, 0, 0); beat("clr no stale b", 0, 0, 0, 0);
        step(0, 0, 0, 1, 0); beat("clr e7", 1, 8'hE7, 0, 1);
        step(0, 0, 0, 1, 0); beat("clr end", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
